txll_arb: RTL and testbench
===========================

Name: txll_arb

Overview:
- Two-requester frame arbiter and scheduler for the SATA transmit link-layer FIFO.
- Accepts LocalLink frames from a command-FIS source (port 0) and a data-FIS source (port 1), one whole frame at a time, round-robin.
- Packs each beat into the 36-bit FIFO word format: bit35 = sof, bit34 = eof, bits33:32 = 0, bits31:0 = data.
- Tracks completed frames resident in the FIFO and drives eof_rdy to the FIFO read-side link logic. Enforces a frame-length limit.

Parameters:
- C_MAX_FRAMES, 4: max complete frames resident in the FIFO; no new grant while the count equals this value.
- C_MAX_WORDS, 2049: max beats per frame (1 header dword + 8192 bytes).
- C_CNT_W, 3: frame counter width; must satisfy 2^C_CNT_W > C_MAX_FRAMES.

Ports:
- phyclk  in  1  Single clock.
- phyreset  in  1  Synchronous, active-high reset.
- src0_td  in  32  Port 0 (command) data.
- src0_sof_n  in  1  Port 0 start of frame, active low.
- src0_eof_n  in  1  Port 0 end of frame, active low.
- src0_src_rdy_n  in  1  Port 0 beat valid, active low.
- src0_dst_rdy_n  out  1  Port 0 beat accepted, active low.
- src1_td, src1_sof_n, src1_eof_n, src1_src_rdy_n  in  32/1/1/1  Port 1 (data), same meaning as port 0.
- src1_dst_rdy_n  out  1  Port 1 accept, active low.
- wr_do  out  36  FIFO write word.
- wr_en  out  1  FIFO write strobe.
- wr_full  in  1  FIFO full; no write may occur while high.
- rd_eof  in  1  Pulse: FIFO read side consumed a word with bit34 set.
- eof_rdy  out  1  At least one complete frame is in the FIFO.
- err_len  out  1  One-cycle pulse: frame truncated at C_MAX_WORDS.
- busy  out  1  Arbiter is not in IDLE.

Behaviour:
- Reset (phyreset=1 at a clock edge):
  - state=IDLE, last=1 (so port 0 wins first), frm_cnt=0, wcnt=0.
  - All dst_rdy_n=1, wr_en=0, eof_rdy=0, err_len=0, busy=0.
  - Reset mid-frame abandons the frame. Any partial frame already in the FIFO is the FIFO owner's problem; the FIFO is reset by the same signal.
- Requester eligibility: port i is eligible when srci_src_rdy_n=0 and srci_sof_n=0. A non-sof beat from an ungranted port is never accepted; it stalls.
- IDLE:
  - If frm_cnt < C_MAX_FRAMES and at least one port is eligible, register a grant at the edge and move to XFER.
  - Round-robin: if both ports are eligible, grant the port that is not `last`. If one is eligible, grant it.
  - No beat is accepted in the decision cycle. Minimum latency is 1 cycle from sof valid to first accept.
- XFER:
  - Granted port's dst_rdy_n = wr_full (combinational). Other port's dst_rdy_n = 1.
  - Beat accepted when src_rdy_n=0 and dst_rdy_n=0. On accept: wr_en=1 the same cycle, wr_do={~sof_n, ~eof_n, 2'b00, td}, wcnt+1.
  - Accepted beat with eof: frm_cnt+1, last=granted port, wcnt=0, go to IDLE.
  - Accepted beat with wcnt==C_MAX_WORDS-1 and no eof: write it with bit34 forced to 1, frm_cnt+1, err_len=1 for one cycle, last=granted port, wcnt=0, go to DRAIN.
  - A sof on a non-first beat is passed through unchanged; it is not checked.
- DRAIN:
  - Granted port's dst_rdy_n=0 regardless of wr_full. wr_en=0; beats are discarded.
  - On the discarded eof beat, go to IDLE.
- Frame counter:
  - Write-eof only: +1. rd_eof only: -1. Both in the same cycle: unchanged.
  - rd_eof while frm_cnt=0 is ignored; the counter stays 0.
  - Never exceeds C_MAX_FRAMES, because grants are blocked at the limit.
- eof_rdy = (frm_cnt != 0), registered from the counter, so it updates the cycle after the eof write.
- busy = (state != IDLE).
- wr_en is never high while wr_full=1.

Test Plan:
- Port 0 sends a 3-beat frame (0xA0,0xA1,0xA2), wr_full=0 -> 1 idle cycle, then wr_do = 0x8_000000A0, 0x0_000000A1, 0x4_000000A2 on consecutive cycles. eof_rdy rises the cycle after the last write.
- Both ports present sof in the same cycle after reset -> port 0 frame written first, then port 1. Repeat the same simultaneous request -> port 0 first again, because last=1 after port 1's frame. Alternation holds over 4 frames.
- wr_full=1 for 5 cycles mid-frame -> granted dst_rdy_n=1 and wr_en=0 during those cycles. Data resumes intact with no loss or duplication.
- 4 frames written, rd_eof never pulsed -> frm_cnt=4, a 5th sof stalls with busy=0. One rd_eof pulse -> grant within 2 cycles. rd_eof coincident with an eof write -> frm_cnt unchanged.
- C_MAX_WORDS=4, 7-beat frame -> 4 words written with bit34 set on the 4th, err_len pulses once, beats 5-7 accepted but not written, then IDLE.
- phyreset asserted mid-XFER -> next cycle all outputs at reset values. A new sof on port 1 is granted normally after release.

Source files
------------

// File: rtl/txll_arb_if.sv
// Transmit link-layer arbiter bus: two LocalLink frame sources, the FIFO
// write port and the frame-availability handshake with the FIFO read side.
interface txll_arb_if;
    // LocalLink sources: a beat moves on a clock edge where src_rdy_n and
    // dst_rdy_n are both low; the source holds the beat stable until then.
    logic [31:0] src0_td;
    logic        src0_sof_n;
    logic        src0_eof_n;
    logic        src0_src_rdy_n;
    logic        src0_dst_rdy_n;
    logic [31:0] src1_td;
    logic        src1_sof_n;
    logic        src1_eof_n;
    logic        src1_src_rdy_n;
    logic        src1_dst_rdy_n;

    logic [35:0] wr_do;
    logic        wr_en;
    logic        wr_full;
    logic        rd_eof;
    logic        eof_rdy;
    logic        err_len;
    logic        busy;
    logic [1:0]  dbg_state;

    modport slave (
        input  src0_td, src0_sof_n, src0_eof_n, src0_src_rdy_n,
        output src0_dst_rdy_n,
        input  src1_td, src1_sof_n, src1_eof_n, src1_src_rdy_n,
        output src1_dst_rdy_n,
        output wr_do, wr_en,
        input  wr_full, rd_eof,
        output eof_rdy, err_len, busy, dbg_state
    );

    modport master (
        output src0_td, src0_sof_n, src0_eof_n, src0_src_rdy_n,
        input  src0_dst_rdy_n,
        output src1_td, src1_sof_n, src1_eof_n, src1_src_rdy_n,
        input  src1_dst_rdy_n,
        input  wr_do, wr_en,
        output wr_full, rd_eof,
        input  eof_rdy, err_len, busy, dbg_state
    );
endinterface

// File: rtl/txll_arb.sv
// Round-robin whole-frame arbiter between the command and data FIS sources,
// packing beats into 36-bit FIFO words and tracking complete frames resident.
module txll_arb #(
    parameter int C_MAX_FRAMES = 4,
    parameter int C_MAX_WORDS  = 2049,
    parameter int C_CNT_W      = 3
) (
    input logic       phyclk,
    input logic       phyreset,
    txll_arb_if.slave bus
);
    localparam int WCNT_W = (C_MAX_WORDS > 1) ? $clog2(C_MAX_WORDS) : 1;
    localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(C_MAX_WORDS - 1);
    localparam logic [C_CNT_W-1:0] CNT_MAX   = C_CNT_W'(C_MAX_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic [C_CNT_W-1:0]  frm_cnt_q, frm_cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                eof_rdy_q;

    logic                elig0, elig1;
    logic [31:0]         g_td;
    logic                g_sof_n, g_eof_n, g_src_rdy_n;
    logic                g_dst_rdy_n;
    logic                wr_en, wr_eof, err_len, rd_dec;
    logic [35:0]         wr_do;

    assign elig0 = !bus.src0_src_rdy_n && !bus.src0_sof_n;
    assign elig1 = !bus.src1_src_rdy_n && !bus.src1_sof_n;

    assign g_td        = gnt_q ? bus.src1_td        : bus.src0_td;
    assign g_sof_n     = gnt_q ? bus.src1_sof_n     : bus.src0_sof_n;
    assign g_eof_n     = gnt_q ? bus.src1_eof_n     : bus.src0_eof_n;
    assign g_src_rdy_n = gnt_q ? bus.src1_src_rdy_n : bus.src0_src_rdy_n;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        wcnt_d      = wcnt_q;
        g_dst_rdy_n = 1'b1;
        wr_en       = 1'b0;
        wr_do       = 36'd0;
        wr_eof      = 1'b0;
        err_len     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The grant is only registered here; the first beat moves next cycle.
                if ((frm_cnt_q < CNT_MAX) && (elig0 || elig1)) begin
                    gnt_d   = (elig0 && elig1) ? ~last_q : elig1;
                    wcnt_d  = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                g_dst_rdy_n = bus.wr_full;
                if (!g_src_rdy_n && !bus.wr_full) begin
                    wr_en = 1'b1;
                    wr_do = {~g_sof_n, ~g_eof_n, 2'b00, g_td};
                    if (!g_eof_n) begin
                        wr_eof  = 1'b1;
                        last_d  = gnt_q;
                        wcnt_d  = '0;
                        state_d = S_IDLE;
                    end else if (wcnt_q == WCNT_LAST) begin
                        // Overlong frame: close it in the FIFO, swallow the rest.
                        wr_do[34] = 1'b1;
                        wr_eof    = 1'b1;
                        err_len   = 1'b1;
                        last_d    = gnt_q;
                        wcnt_d    = '0;
                        state_d   = S_DRAIN;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                g_dst_rdy_n = 1'b0;
                if (!g_src_rdy_n && !g_eof_n) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A read-side eof with nothing counted is spurious and dropped.
    assign rd_dec = bus.rd_eof && (frm_cnt_q != '0);

    always_comb begin
        frm_cnt_d = frm_cnt_q;
        if (wr_eof && !rd_dec) begin
            frm_cnt_d = frm_cnt_q + C_CNT_W'(1);
        end else if (!wr_eof && rd_dec) begin
            frm_cnt_d = frm_cnt_q - C_CNT_W'(1);
        end
    end

    always_ff @(posedge phyclk) begin
        if (phyreset) begin
            state_q   <= S_IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            frm_cnt_q <= '0;
            wcnt_q    <= '0;
            eof_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            frm_cnt_q <= frm_cnt_d;
            wcnt_q    <= wcnt_d;
            eof_rdy_q <= (frm_cnt_d != '0);
        end
    end

    assign bus.src0_dst_rdy_n = gnt_q ? 1'b1 : g_dst_rdy_n;
    assign bus.src1_dst_rdy_n = gnt_q ? g_dst_rdy_n : 1'b1;
    assign bus.wr_en          = wr_en;
    assign bus.wr_do          = wr_do;
    assign bus.err_len        = err_len;
    assign bus.eof_rdy        = eof_rdy_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_txll_arb.sv
// Bench for txll_arb: frame-level reference model (expected word queue,
// round-robin winner, resident-frame count) against randomized sources.
module tb_txll_arb;
    logic phyclk   = 1'b0;
    logic phyreset = 1'b1;

    always #5 phyclk = ~phyclk;

    txll_arb_if bus_a ();
    txll_arb_if bus_b ();

    txll_arb u_dut_a (
        .phyclk   (phyclk),
        .phyreset (phyreset),
        .bus      (bus_a.slave)
    );

    txll_arb #(.C_MAX_WORDS(4)) u_dut_b (
        .phyclk   (phyclk),
        .phyreset (phyreset),
        .bus      (bus_b.slave)
    );

    assign bus_b.src0_td        = bus_a.src0_td;
    assign bus_b.src0_sof_n     = bus_a.src0_sof_n;
    assign bus_b.src0_eof_n     = bus_a.src0_eof_n;
    assign bus_b.src0_src_rdy_n = bus_a.src0_src_rdy_n;
    assign bus_b.src1_td        = bus_a.src1_td;
    assign bus_b.src1_sof_n     = bus_a.src1_sof_n;
    assign bus_b.src1_eof_n     = bus_a.src1_eof_n;
    assign bus_b.src1_src_rdy_n = bus_a.src1_src_rdy_n;
    assign bus_b.wr_full        = bus_a.wr_full;
    assign bus_b.rd_eof         = bus_a.rd_eof;

    logic [35:0] exp_q[$];
    logic [35:0] exp_b[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  m_cnt = 0;
    bit  m_last = 1'b1;
    bit  rd_mode = 1'b0;
    bit  full_mode = 1'b0;
    bit  b_chk = 1'b0;
    int  n_wr_a = 0;
    int  n_wr_b = 0;
    int  b_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    // Reference monitor: words in order, frame count drives eof_rdy a cycle later.
    always @(negedge phyclk) begin
        if (!phyreset) begin
            bit w_eof, r_dec;
            chk("eof_rdy", bus_a.eof_rdy, (m_cnt != 0));
            chk("err_len_a", bus_a.err_len, 1'b0);
            w_eof = 1'b0;
            if (bus_a.wr_en) begin
                n_wr_a++;
                chk("wr_while_full", bus_a.wr_full, 1'b0);
                if (exp_q.size() == 0) chk("unexpected_write", bus_a.wr_do, 64'hdead);
                else chk("wr_do", bus_a.wr_do, exp_q.pop_front());
                w_eof = bus_a.wr_do[34];
            end
            r_dec = bus_a.rd_eof && (m_cnt > 0);
            if (w_eof && !r_dec) m_cnt++;
            else if (r_dec && !w_eof) m_cnt--;
        end
    end

    always @(negedge phyclk) begin
        if (!phyreset && b_chk) begin
            if (bus_b.err_len) b_err++;
            if (bus_b.wr_en) begin
                n_wr_b++;
                if (exp_b.size() == 0) chk("unexpected_write_b", bus_b.wr_do, 64'hdead);
                else chk("wr_do_b", bus_b.wr_do, exp_b.pop_front());
            end
        end
    end

    always @(posedge phyclk) begin
        #1;
        if (rd_mode) bus_a.rd_eof = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
        if (full_mode) bus_a.wr_full = ($urandom_range(0, 3) == 0);
    end

    task automatic set_src(input int p, input logic vld_n, input logic sof_n,
                           input logic eof_n, input logic [31:0] td);
        if (p == 0) begin
            bus_a.src0_src_rdy_n = vld_n; bus_a.src0_sof_n = sof_n;
            bus_a.src0_eof_n = eof_n;     bus_a.src0_td = td;
        end else begin
            bus_a.src1_src_rdy_n = vld_n; bus_a.src1_sof_n = sof_n;
            bus_a.src1_eof_n = eof_n;     bus_a.src1_td = td;
        end
    endtask

    function automatic logic accepted(input int p);
        if (p == 0) return !bus_a.src0_src_rdy_n && !bus_a.src0_dst_rdy_n;
        return !bus_a.src1_src_rdy_n && !bus_a.src1_dst_rdy_n;
    endfunction

    task automatic do_reset();
        rd_mode = 1'b0; full_mode = 1'b0; b_chk = 1'b0;
        phyreset = 1'b1;
        exp_q.delete(); exp_b.delete();
        m_cnt = 0; m_last = 1'b1;
        set_src(0, 1'b1, 1'b1, 1'b1, '0);
        set_src(1, 1'b1, 1'b1, 1'b1, '0);
        bus_a.wr_full = 1'b0; bus_a.rd_eof = 1'b0;
        repeat (2) @(posedge phyclk);
        #1 phyreset = 1'b0;
    endtask

    task automatic push_frame(input int len, input logic [31:0] d0);
        for (int k = 0; k < len; k++)
            exp_q.push_back({(k == 0), (k == len - 1), 2'b00, d0 + 32'(k)});
    endtask

    // Presents one frame beat by beat; called and returns at posedge+1.
    task automatic drive_port(input int p, input int len, input logic [31:0] d0, input bit gaps);
        int k = 0;
        int guard = 0;
        logic gap;
        while (k < len && guard < 2000) begin
            gap = gaps && (k > 0) && ($urandom_range(0, 3) == 0);
            set_src(p, gap, (k == 0) ? 1'b0 : 1'b1, (k == len - 1) ? 1'b0 : 1'b1, d0 + 32'(k));
            @(negedge phyclk);
            if (accepted(p)) k++;
            guard++;
            @(posedge phyclk); #1;
        end
        set_src(p, 1'b1, 1'b1, 1'b1, '0);
        chk($sformatf("beats_p%0d", p), 64'(k), 64'(len));
    endtask

    task automatic do_round(input bit en0, input bit en1, input int len0, input int len1, input bit gaps);
        logic [31:0] d0, d1;
        int first;
        d0 = $urandom; d1 = $urandom;
        if (en0 && en1) first = m_last ? 0 : 1;
        else first = en1 ? 1 : 0;
        if (first == 0) begin
            if (en0) push_frame(len0, d0);
            if (en1) push_frame(len1, d1);
        end else begin
            push_frame(len1, d1);
            if (en0) push_frame(len0, d0);
        end
        m_last = (en0 && en1) ? (first == 0) : (first == 1);
        fork
            begin if (en0) drive_port(0, len0, d0, gaps); end
            begin if (en1) drive_port(1, len1, d1, gaps); end
        join
        chk("round_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_rd();
        bus_a.rd_eof = 1'b1;
        @(posedge phyclk); #1 bus_a.rd_eof = 1'b0;
        @(negedge phyclk);
        @(posedge phyclk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int base;
        do_reset();

        // Reset values.
        @(negedge phyclk);
        chk("rst_dst0", bus_a.src0_dst_rdy_n, 1'b1);
        chk("rst_dst1", bus_a.src1_dst_rdy_n, 1'b1);
        chk("rst_wr_en", bus_a.wr_en, 1'b0);
        chk("rst_busy", bus_a.busy, 1'b0);
        chk("rst_state", bus_a.dbg_state, 2'd0);
        @(posedge phyclk); #1;

        // Port 0, 3-beat frame with exact cycle timing.
        push_frame(3, 32'hA0);
        set_src(0, 1'b0, 1'b0, 1'b1, 32'hA0);
        @(negedge phyclk);
        chk("lat_dst0", bus_a.src0_dst_rdy_n, 1'b1);
        chk("lat_wr_en", bus_a.wr_en, 1'b0);
        @(posedge phyclk); #1;
        @(negedge phyclk);
        chk("w0", bus_a.wr_do, 36'h8000000A0);
        @(posedge phyclk); #1 set_src(0, 1'b0, 1'b1, 1'b1, 32'hA1);
        @(negedge phyclk);
        chk("w1", bus_a.wr_do, 36'h0000000A1);
        @(posedge phyclk); #1 set_src(0, 1'b0, 1'b1, 1'b0, 32'hA2);
        @(negedge phyclk);
        chk("w2", bus_a.wr_do, 36'h4000000A2);
        chk("eof_rdy_at_write", bus_a.eof_rdy, 1'b0);
        @(posedge phyclk); #1 set_src(0, 1'b1, 1'b1, 1'b1, '0);
        @(negedge phyclk);
        chk("eof_rdy_after", bus_a.eof_rdy, 1'b1);
        chk("busy_after", bus_a.busy, 1'b0);
        @(posedge phyclk); #1;

        // Simultaneous requests: port 0 first in each round.
        do_reset();
        rd_mode = 1'b1;
        do_round(1'b1, 1'b1, 2, 3, 1'b1);
        do_round(1'b1, 1'b1, 3, 1, 1'b1);

        // wr_full held for 5 cycles mid-frame.
        do_reset();
        d = $urandom;
        push_frame(6, d);
        base = n_wr_a;
        fork
            drive_port(0, 6, d, 1'b0);
            begin
                for (int i = 0; i < 50; i++) begin
                    if (n_wr_a >= base + 2) break;
                    @(posedge phyclk); #1;
                end
                bus_a.wr_full = 1'b1;
                repeat (5) begin
                    @(negedge phyclk);
                    chk("full_dst0", bus_a.src0_dst_rdy_n, 1'b1);
                    chk("full_wr_en", bus_a.wr_en, 1'b0);
                    @(posedge phyclk); #1;
                end
                bus_a.wr_full = 1'b0;
            end
        join
        chk("full_left", 64'(exp_q.size()), 64'd0);

        // Frame limit, release by rd_eof, coincident rd_eof and eof write.
        do_reset();
        do_round(1'b1, 1'b0, 2, 0, 1'b0);
        do_round(1'b0, 1'b1, 0, 3, 1'b0);
        do_round(1'b1, 1'b0, 1, 0, 1'b0);
        do_round(1'b0, 1'b1, 0, 2, 1'b0);
        push_frame(1, 32'h5555_0000);
        set_src(0, 1'b0, 1'b0, 1'b0, 32'h5555_0000);
        repeat (5) begin
            @(negedge phyclk);
            chk("limit_busy", bus_a.busy, 1'b0);
            chk("limit_dst0", bus_a.src0_dst_rdy_n, 1'b1);
            @(posedge phyclk); #1;
        end
        bus_a.rd_eof = 1'b1;
        @(posedge phyclk); #1 bus_a.rd_eof = 1'b0;
        @(negedge phyclk);
        chk("release_decide", bus_a.busy, 1'b0);
        @(posedge phyclk); #1 bus_a.rd_eof = 1'b1;
        @(negedge phyclk);
        chk("release_busy", bus_a.busy, 1'b1);
        chk("release_wr", bus_a.wr_en, 1'b1);
        @(posedge phyclk); #1 bus_a.rd_eof = 1'b0;
        set_src(0, 1'b1, 1'b1, 1'b1, '0);
        pulse_rd();
        pulse_rd();
        @(negedge phyclk);
        chk("cnt_one_left", bus_a.eof_rdy, 1'b1);
        @(posedge phyclk); #1;
        pulse_rd();
        @(negedge phyclk);
        chk("cnt_empty", bus_a.eof_rdy, 1'b0);
        @(posedge phyclk); #1;
        pulse_rd();
        do_round(1'b1, 1'b0, 1, 0, 1'b0);
        @(negedge phyclk);
        chk("cnt_after_spurious", bus_a.eof_rdy, 1'b1);
        @(posedge phyclk); #1;
        pulse_rd();
        @(negedge phyclk);
        chk("cnt_back_zero", bus_a.eof_rdy, 1'b0);
        @(posedge phyclk); #1;

        // Truncation on the 4-word instance.
        do_reset();
        b_chk = 1'b1;
        n_wr_b = 0; b_err = 0;
        d = $urandom;
        push_frame(7, d);
        for (int k = 0; k < 4; k++)
            exp_b.push_back({(k == 0), (k == 3), 2'b00, d + 32'(k)});
        drive_port(0, 7, d, 1'b1);
        @(negedge phyclk);
        chk("trunc_words", 64'(n_wr_b), 64'd4);
        chk("trunc_err_pulses", 64'(b_err), 64'd1);
        chk("trunc_busy", bus_b.busy, 1'b0);
        chk("trunc_eof_rdy", bus_b.eof_rdy, 1'b1);
        chk("trunc_left", 64'(exp_b.size()), 64'd0);
        @(posedge phyclk); #1;
        b_chk = 1'b0;

        // Reset in the middle of a transfer.
        do_reset();
        exp_q.push_back({1'b1, 1'b0, 2'b00, 32'hC0DE_0000});
        set_src(0, 1'b0, 1'b0, 1'b1, 32'hC0DE_0000);
        @(negedge phyclk);
        @(posedge phyclk); #1;
        @(negedge phyclk);
        chk("midx_busy", bus_a.busy, 1'b1);
        @(posedge phyclk); #1;
        set_src(0, 1'b0, 1'b1, 1'b1, 32'hC0DE_0001);
        phyreset = 1'b1;
        exp_q.delete(); m_cnt = 0; m_last = 1'b1;
        @(posedge phyclk); #1 phyreset = 1'b0;
        @(negedge phyclk);
        chk("midrst_dst0", bus_a.src0_dst_rdy_n, 1'b1);
        chk("midrst_dst1", bus_a.src1_dst_rdy_n, 1'b1);
        chk("midrst_wr_en", bus_a.wr_en, 1'b0);
        chk("midrst_busy", bus_a.busy, 1'b0);
        chk("midrst_eof_rdy", bus_a.eof_rdy, 1'b0);
        @(posedge phyclk); #1;
        set_src(0, 1'b1, 1'b1, 1'b1, '0);
        do_round(1'b0, 1'b1, 0, 2, 1'b0);

        // Randomized rounds with random back-pressure and read-side drain.
        do_reset();
        full_mode = 1'b1;
        rd_mode = 1'b1;
        for (int r = 0; r < 30; r++) begin
            int sel;
            sel = $urandom_range(1, 3);
            do_round(sel[0], sel[1], $urandom_range(1, 6), $urandom_range(1, 6), 1'b1);
        end
        full_mode = 1'b0;
        rd_mode = 1'b0;
        @(posedge phyclk); #1;
        bus_a.wr_full = 1'b0;
        bus_a.rd_eof = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
